// File: rtl/can_pkg.sv
// Shared types and widths for the CAN transmit mailbox scheduler.
package can_pkg;

  localparam int CAN_ID_W  = 29;
  localparam int CAN_DLC_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3
  } can_state_e;

endpackage

// File: rtl/can_mb_prio_sel.sv
// Combinational priority selector: lowest identifier among pending mailboxes,
// lowest index on equal identifiers.
module can_mb_prio_sel
  import can_pkg::*;
#(
  parameter int NUM_MB = 4,
  parameter int IDX_W  = $clog2(NUM_MB)
) (
  input  logic [NUM_MB-1:0]               pend_i,
  input  logic [NUM_MB-1:0][CAN_ID_W-1:0] id_i,
  output logic                            valid_o,
  output logic [IDX_W-1:0]                idx_o,
  output logic [CAN_ID_W-1:0]             id_o
);

  logic take_s;

  // Linear scan; strict less-than keeps the earlier index on a tie.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    id_o    = '0;
    take_s  = 1'b0;
    for (int i = 0; i < NUM_MB; i++) begin
      take_s  = pend_i[i] && (!valid_o || (id_i[i] < id_o));
      idx_o   = take_s ? IDX_W'(i) : idx_o;
      id_o    = take_s ? id_i[i] : id_o;
      valid_o = valid_o | pend_i[i];
    end
  end

endmodule

// File: rtl/can_tx_mailbox_sched.sv
// CAN TX mailbox scheduler: picks the highest-priority pending mailbox and hands it
// to the frame transmitter. Optional retry limit enabled by CAN_MB_RETRY_LIMIT_EN.
module can_tx_mailbox_sched
  import can_pkg::*;
#(
  parameter int NUM_MB    = 4,
  parameter int RETRY_MAX = 8,
  parameter int DATA_W    = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mb_wr_i,
  input  logic [$clog2(NUM_MB)-1:0] mb_wr_idx_i,
  input  logic [CAN_ID_W-1:0]       mb_id_i,
  input  logic [CAN_DLC_W-1:0]      mb_dlc_i,
  input  logic [DATA_W-1:0]         mb_data_i,
  input  logic [NUM_MB-1:0]         mb_abort_i,
  input  logic                      bus_idle_i,
  input  logic                      tx_ack_i,
  input  logic                      tx_lost_i,
  output logic                      tx_start_o,
  output logic [CAN_ID_W-1:0]       tx_id_o,
  output logic [CAN_DLC_W-1:0]      tx_dlc_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic [NUM_MB-1:0]         mb_pending_o,
  output logic                      wr_rej_o,
  output logic                      done_o,
  output logic [$clog2(NUM_MB)-1:0] done_idx_o,
  output logic                      err_o,
  output logic [$clog2(NUM_MB)-1:0] err_idx_o,
  output logic [2:0]                state_o
);

  localparam int IDX_W = $clog2(NUM_MB);

  // An out-of-range configuration elaborates this marker block.
  if (NUM_MB < 2 || NUM_MB > 16 || RETRY_MAX < 1) begin : g_bad_params
  end

  can_state_e                        state_q, state_d;
  logic [NUM_MB-1:0]                 pend_q, pend_d;
  logic [NUM_MB-1:0][CAN_ID_W-1:0]   id_q, id_d;
  logic [NUM_MB-1:0][CAN_DLC_W-1:0]  dlc_q, dlc_d;
  logic [NUM_MB-1:0][DATA_W-1:0]     data_q, data_d;
  logic [IDX_W-1:0]                  cur_q, cur_d;
  logic                              abort_q, abort_d;
  logic                              tx_start_q, tx_start_d;
  logic [CAN_ID_W-1:0]               tx_id_q, tx_id_d;
  logic [CAN_DLC_W-1:0]              tx_dlc_q, tx_dlc_d;
  logic [DATA_W-1:0]                 tx_data_q, tx_data_d;
  logic                              wr_rej_q, wr_rej_d;
  logic                              done_q, done_d;
  logic [IDX_W-1:0]                  done_idx_q, done_idx_d;

  logic                              sel_valid_s;
  logic [IDX_W-1:0]                  sel_idx_s;
  logic [CAN_ID_W-1:0]               sel_id_s;
  logic                              in_flight_s;
  logic                              wr_hit_s;
  logic                              wr_ok_s;
  logic                              launch_s;
  logic                              fin_s;
  logic                              fin_abort_s;
  logic                              limit_hit_s;
  logic                              drop_s;

  can_mb_prio_sel #(
    .NUM_MB (NUM_MB),
    .IDX_W  (IDX_W)
  ) u_prio_sel (
    .pend_i  (pend_q),
    .id_i    (id_q),
    .valid_o (sel_valid_s),
    .idx_o   (sel_idx_s),
    .id_o    (sel_id_s)
  );

  // The latched winner is "in flight" from START until its completion pulse.
  assign in_flight_s = (state_q == ST_START) || (state_q == ST_WAIT);
  assign wr_hit_s    = mb_wr_i && in_flight_s && (mb_wr_idx_i == cur_q);
  assign wr_ok_s     = mb_wr_i && !wr_hit_s &&
                       ({1'b0, mb_wr_idx_i} < (IDX_W+1)'(NUM_MB));
  assign launch_s    = (state_q == ST_ARB) && sel_valid_s;
  assign fin_s       = (state_q == ST_WAIT) && (tx_ack_i || tx_lost_i);
  assign fin_abort_s = abort_q || mb_abort_i[cur_q];
  assign drop_s      = fin_s && (tx_ack_i || fin_abort_s || limit_hit_s);

`ifdef CAN_MB_RETRY_LIMIT_EN
  localparam int                 RTRY_W    = $clog2(RETRY_MAX + 1);
  localparam logic [RTRY_W-1:0]  RETRY_SAT = RTRY_W'(RETRY_MAX);

  logic [NUM_MB-1:0][RTRY_W-1:0] retry_q, retry_d;
  logic [RTRY_W-1:0]             retry_inc_s;
  logic                          err_q, err_d;
  logic [IDX_W-1:0]              err_idx_q, err_idx_d;

  assign retry_inc_s = (retry_q[cur_q] == RETRY_SAT) ? RETRY_SAT
                                                     : retry_q[cur_q] + RTRY_W'(1);
  assign limit_hit_s = (retry_inc_s == RETRY_SAT);

  // Retry bookkeeping: bump on a plain loss, clear on an accepted write.
  always_comb begin
    retry_d   = retry_q;
    retry_d[cur_q] = (fin_s && !tx_ack_i && !fin_abort_s) ? retry_inc_s : retry_q[cur_q];
    if (wr_ok_s) begin
      retry_d[mb_wr_idx_i] = '0;
    end else begin
      retry_d[mb_wr_idx_i] = retry_d[mb_wr_idx_i];
    end
    err_d     = fin_s && !tx_ack_i && !fin_abort_s && limit_hit_s;
    err_idx_d = err_d ? cur_q : '0;
  end

  // Retry counters and error pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retry_q   <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      retry_q   <= retry_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign err_o     = err_q;
  assign err_idx_o = err_idx_q;
`else
  assign limit_hit_s = 1'b0;
  assign err_o       = 1'b0;
  assign err_idx_o   = '0;
`endif

  // Next state plus the launch-time latch of the transmitted frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ((|pend_q) && bus_idle_i) ? ST_ARB : ST_IDLE;
      ST_ARB:   state_d = sel_valid_s ? ST_START : ST_IDLE;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  state_d = (tx_ack_i || tx_lost_i) ? ST_IDLE : ST_WAIT;
      default:  state_d = ST_IDLE;
    endcase
    tx_start_d = launch_s;
    tx_id_d    = launch_s ? sel_id_s          : tx_id_q;
    tx_dlc_d   = launch_s ? dlc_q[sel_idx_s]  : tx_dlc_q;
    tx_data_d  = launch_s ? data_q[sel_idx_s] : tx_data_q;
    cur_d      = launch_s ? sel_idx_s         : cur_q;
    abort_d    = launch_s ? 1'b0 : (abort_q || (in_flight_s && mb_abort_i[cur_q]));
    wr_rej_d   = wr_hit_s;
    done_d     = fin_s && tx_ack_i;
    done_idx_d = done_d ? cur_q : '0;
  end

  // Pending flags: immediate abort unless in flight, completion drop, write wins last.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_MB; i++) begin
      pend_d[i] = pend_q[i] & ~(mb_abort_i[i] & ~(in_flight_s && (IDX_W'(i) == cur_q)));
    end
    pend_d[cur_q] = pend_d[cur_q] & ~drop_s;
    if (wr_ok_s) begin
      pend_d[mb_wr_idx_i] = 1'b1;
    end else begin
      pend_d[mb_wr_idx_i] = pend_d[mb_wr_idx_i];
    end
  end

  // Mailbox contents, loaded by accepted writes only.
  always_comb begin
    id_d   = id_q;
    dlc_d  = dlc_q;
    data_d = data_q;
    if (wr_ok_s) begin
      id_d[mb_wr_idx_i]   = mb_id_i;
      dlc_d[mb_wr_idx_i]  = mb_dlc_i;
      data_d[mb_wr_idx_i] = mb_data_i;
    end else begin
      id_d = id_q;
    end
  end

  // Mailbox payload storage carries no reset; the pending flag gates its use.
  always_ff @(posedge clk_i) begin
    id_q   <= id_d;
    dlc_q  <= dlc_d;
    data_q <= data_d;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      cur_q      <= '0;
      abort_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_id_q    <= '0;
      tx_dlc_q   <= '0;
      tx_data_q  <= '0;
      wr_rej_q   <= 1'b0;
      done_q     <= 1'b0;
      done_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cur_q      <= cur_d;
      abort_q    <= abort_d;
      tx_start_q <= tx_start_d;
      tx_id_q    <= tx_id_d;
      tx_dlc_q   <= tx_dlc_d;
      tx_data_q  <= tx_data_d;
      wr_rej_q   <= wr_rej_d;
      done_q     <= done_d;
      done_idx_q <= done_idx_d;
    end
  end

  assign tx_start_o   = tx_start_q;
  assign tx_id_o      = tx_id_q;
  assign tx_dlc_o     = tx_dlc_q;
  assign tx_data_o    = tx_data_q;
  assign mb_pending_o = pend_q;
  assign wr_rej_o     = wr_rej_q;
  assign done_o       = done_q;
  assign done_idx_o   = done_idx_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_can_tx_mailbox_sched.sv
// Self-checking bench for can_tx_mailbox_sched: directed scenarios plus random
// traffic compared every cycle against a mailbox-level reference model.
module tb_can_tx_mailbox_sched;
  import can_pkg::*;

  localparam int NUM_MB    = 4;
  localparam int RETRY_MAX = 3;
  localparam int DATA_W    = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              wr = 1'b0;
  logic [1:0]        wr_idx = 2'd0;
  logic [28:0]       wr_id = 29'd0;
  logic [3:0]        wr_dlc = 4'd0;
  logic [63:0]       wr_data = 64'd0;
  logic [3:0]        abort = 4'd0;
  logic              bus_idle = 1'b0;
  logic              ack = 1'b0;
  logic              lost = 1'b0;

  logic              tx_start_o;
  logic [28:0]       tx_id_o;
  logic [3:0]        tx_dlc_o;
  logic [63:0]       tx_data_o;
  logic [3:0]        mb_pending_o;
  logic              wr_rej_o, done_o, err_o;
  logic [1:0]        done_idx_o, err_idx_o;
  logic [2:0]        state_o;

  can_tx_mailbox_sched #(.NUM_MB(NUM_MB), .RETRY_MAX(RETRY_MAX), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst), .mb_wr_i(wr), .mb_wr_idx_i(wr_idx), .mb_id_i(wr_id),
    .mb_dlc_i(wr_dlc), .mb_data_i(wr_data), .mb_abort_i(abort), .bus_idle_i(bus_idle),
    .tx_ack_i(ack), .tx_lost_i(lost), .tx_start_o(tx_start_o), .tx_id_o(tx_id_o),
    .tx_dlc_o(tx_dlc_o), .tx_data_o(tx_data_o), .mb_pending_o(mb_pending_o),
    .wr_rej_o(wr_rej_o), .done_o(done_o), .done_idx_o(done_idx_o), .err_o(err_o),
    .err_idx_o(err_idx_o), .state_o(state_o)
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  // Reference model: mailbox arrays, a phase number and the expected outputs.
  logic [28:0] m_id   [NUM_MB];
  logic [3:0]  m_dlc  [NUM_MB];
  logic [63:0] m_data [NUM_MB];
  int          m_retries [NUM_MB];
  logic [NUM_MB-1:0] m_pend;
  int  m_phase;   // 0 idle, 1 arbitrate, 2 start, 3 wait
  int  m_cur;
  bit  m_abt;
  bit  e_start, e_rej, e_done, e_err;
  logic [28:0] e_id;
  logic [3:0]  e_dlc;
  logic [63:0] e_data;
  int  e_done_idx, e_err_idx;

  function automatic logic [2:0] phase_state(input int ph);
    case (ph)
      0:       return ST_IDLE;
      1:       return ST_ARB;
      2:       return ST_START;
      default: return ST_WAIT;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NUM_MB-1:0] n_pend;
    bit infl, fin, gone;
    int cur, best;
    if (rst) begin
      m_phase = 0; m_pend = '0; m_cur = 0; m_abt = 1'b0;
      for (int i = 0; i < NUM_MB; i++) m_retries[i] = 0;
      e_start = 0; e_rej = 0; e_done = 0; e_err = 0;
      e_id = '0; e_dlc = '0; e_data = '0; e_done_idx = 0; e_err_idx = 0;
      return;
    end
    infl = (m_phase == 2) || (m_phase == 3);
    cur  = m_cur;
    e_start = 0; e_rej = 0; e_done = 0; e_err = 0;
    n_pend = m_pend;
    for (int i = 0; i < NUM_MB; i++)
      if (abort[i] && !(infl && i == cur)) n_pend[i] = 1'b0;
    fin = (m_phase == 3) && (ack || lost);
    if (fin) begin
      gone = m_abt || abort[cur];
      if (ack) begin
        n_pend[cur] = 1'b0; e_done = 1; e_done_idx = cur;
      end else if (gone) begin
        n_pend[cur] = 1'b0;
      end else begin
        if (m_retries[cur] < RETRY_MAX) m_retries[cur]++;
`ifdef CAN_MB_RETRY_LIMIT_EN
        if (m_retries[cur] == RETRY_MAX) begin
          n_pend[cur] = 1'b0; e_err = 1; e_err_idx = cur;
        end
`endif
      end
    end
    if (infl && abort[cur]) m_abt = 1'b1;
    case (m_phase)
      0: if (m_pend != 0 && bus_idle) m_phase = 1;
      1: begin
        best = -1;
        for (int i = 0; i < NUM_MB; i++)
          if (m_pend[i] && (best < 0 || m_id[i] < m_id[best])) best = i;
        if (best >= 0) begin
          m_cur = best; e_start = 1; m_abt = 1'b0; m_phase = 2;
          e_id = m_id[best]; e_dlc = m_dlc[best]; e_data = m_data[best];
        end else begin
          m_phase = 0;
        end
      end
      2: m_phase = 3;
      default: if (ack || lost) m_phase = 0;
    endcase
    if (wr) begin
      if (infl && int'(wr_idx) == cur) e_rej = 1;
      else begin
        m_id[wr_idx] = wr_id; m_dlc[wr_idx] = wr_dlc; m_data[wr_idx] = wr_data;
        n_pend[wr_idx] = 1'b1; m_retries[wr_idx] = 0;
      end
    end
    m_pend = n_pend;
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_tx_start", tx_start_o, e_start);
      check("m_tx_id", tx_id_o, e_id);
      check("m_tx_dlc", tx_dlc_o, e_dlc);
      check("m_tx_data", tx_data_o, e_data);
      check("m_pending", mb_pending_o, m_pend);
      check("m_wr_rej", wr_rej_o, e_rej);
      check("m_done", done_o, e_done);
      if (e_done) check("m_done_idx", done_idx_o, e_done_idx);
      check("m_err", err_o, e_err);
      if (e_err) check("m_err_idx", err_idx_o, e_err_idx);
      check("m_state", state_o, phase_state(m_phase));
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; abort = '0; ack = 1'b0; lost = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wr_mb(input int idx, input logic [28:0] id, input logic [3:0] dlc,
                       input logic [63:0] data);
    wr = 1'b1; wr_idx = 2'(idx); wr_id = id; wr_dlc = dlc; wr_data = data;
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int k = 0;
    while (tx_start_o !== 1'b1 && k < budget) begin
      tick(); k++;
    end
    check("wait_start_timeout", tx_start_o, 1'b1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_state", state_o, ST_IDLE);
    check("rst_pending", mb_pending_o, 4'b0000);
    check("rst_start", tx_start_o, 1'b0);

    // Lower ID wins regardless of index; start lands two cycles after the IDLE decision.
    bus_idle = 1'b0;
    wr_mb(0, 29'h100, 4'd8, 64'hA0);
    wr_mb(2, 29'h050, 4'd2, 64'hA2);
    bus_idle = 1'b1; tick();
    check("lat_arb_no_start", tx_start_o, 1'b0);
    tick();
    check("lat_start", tx_start_o, 1'b1);
    check("prio_id", tx_id_o, 29'h050);
    check("prio_data", tx_data_o, 64'hA2);
    tick(); pulse_ack();
    check("ack_done", done_o, 1'b1);
    check("ack_done_idx", done_idx_o, 2'd2);
    check("ack_pending", mb_pending_o, 4'b0001);
    tick(); tick();
    check("second_start", tx_start_o, 1'b1);
    check("second_id", tx_id_o, 29'h100);
    tick(); pulse_ack();
    check("second_done_idx", done_idx_o, 2'd0);

    // Equal IDs: lower index first.
    do_reset();
    bus_idle = 1'b0;
    wr_mb(1, 29'h200, 4'd1, 64'h1111);
    wr_mb(3, 29'h200, 4'd3, 64'h3333);
    bus_idle = 1'b1;
    wait_start(8);
    check("tie_data_first", tx_data_o, 64'h1111);
    tick(); pulse_ack();
    check("tie_done_idx", done_idx_o, 2'd1);
    wait_start(8);
    check("tie_data_second", tx_data_o, 64'h3333);
    tick(); pulse_ack();

    // Repeated lost arbitration.
    do_reset();
    wr_mb(0, 29'h010, 4'd4, 64'h55);
    for (int r = 1; r <= 3; r++) begin
      wait_start(8);
      tick(); lost = 1'b1; tick(); lost = 1'b0;
`ifdef CAN_MB_RETRY_LIMIT_EN
      check("retry_err", err_o, (r == 3) ? 1'b1 : 1'b0);
      check("retry_pend0", mb_pending_o[0], (r == 3) ? 1'b0 : 1'b1);
      if (r == 3) check("retry_err_idx", err_idx_o, 2'd0);
`else
      check("retry_err_tied", err_o, 1'b0);
      check("retry_pend0", mb_pending_o[0], 1'b1);
`endif
    end
`ifndef CAN_MB_RETRY_LIMIT_EN
    wait_start(8);
    tick(); pulse_ack();
`endif

    // Write to the in-flight mailbox is rejected.
    do_reset();
    wr_mb(1, 29'h300, 4'd3, 64'hD1D1);
    wait_start(8);
    tick();
    wr_mb(1, 29'h301, 4'd5, 64'hD2D2);
    check("rej_pulse", wr_rej_o, 1'b1);
    check("rej_data_kept", tx_data_o, 64'hD1D1);
    pulse_ack();
    check("rej_done", done_o, 1'b1);
    check("rej_pending", mb_pending_o, 4'b0000);

    // Aborts: idle mailbox clears at once; in-flight abort defers to completion.
    do_reset();
    bus_idle = 1'b0;
    wr_mb(1, 29'h400, 4'd1, 64'h41);
    wr_mb(2, 29'h410, 4'd2, 64'h42);
    abort = 4'b0010; tick(); abort = 4'b0000;
    check("abort_idle_pend", mb_pending_o, 4'b0100);
    check("abort_idle_done", done_o, 1'b0);
    bus_idle = 1'b1;
    wait_start(8);
    check("abort_fl_id", tx_id_o, 29'h410);
    tick();
    abort = 4'b0100; tick(); abort = 4'b0000;
    check("abort_deferred", mb_pending_o[2], 1'b1);
    lost = 1'b1; tick(); lost = 1'b0;
    check("abort_lost_pend", mb_pending_o, 4'b0000);
    check("abort_lost_err", err_o, 1'b0);
    tick(); tick();
    check("abort_no_restart", tx_start_o, 1'b0);

    // Reset during WAIT abandons the frame.
    do_reset();
    wr_mb(0, 29'h020, 4'd2, 64'h20);
    wait_start(8);
    tick();
    rst = 1'b1; ack = 1'b1; tick(); rst = 1'b0; ack = 1'b0;
    check("rstw_state", state_o, ST_IDLE);
    check("rstw_pending", mb_pending_o, 4'b0000);
    check("rstw_done", done_o, 1'b0);
    tick();
    check("rstw_done_after", done_o, 1'b0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      wr       = ($urandom_range(0, 5) == 0);
      wr_idx   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       wr_id = 29'h050;
        1:       wr_id = 29'h100;
        2:       wr_id = 29'h200;
        default: wr_id = 29'($urandom);
      endcase
      wr_dlc   = 4'($urandom_range(0, 15));
      wr_data  = {$urandom, $urandom};
      abort    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      bus_idle = ($urandom_range(0, 4) != 0);
      ack      = ($urandom_range(0, 3) == 0);
      lost     = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0; wr = 1'b0; abort = '0; ack = 1'b0; lost = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
